// File: rtl/bram_port_arbiter.sv
// Two-port arbiter for the single-port vector BRAM: round-robin grant, burst
// ownership with a length watchdog, and in-order 1-cycle read responses.
module bram_port_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 256,
  parameter int MAX_BURST  = 16,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_last,
  input  logic [ADDR_W-1:0]     req_addr0,
  input  logic [ADDR_W-1:0]     req_addr1,
  input  logic [DATA_WIDTH-1:0] req_wdata0,
  input  logic [DATA_WIDTH-1:0] req_wdata1,
  output logic [1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  burst_err,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  state_e     state_q, state_d;
  logic       prio_q, prio_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [1:0] rsp_port_q, rsp_port_d;
  logic       burst_err_q, burst_err_d;

  logic [1:0] accept;
  logic       win;
  logic [8:0] cnt_inc;
  logic       cap_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      beat_cnt_q  <= '0;
      rsp_port_q  <= '0;
      burst_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_port_q  <= rsp_port_d;
      burst_err_q <= burst_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_port_d  = '0;
    burst_err_d = 1'b0;
    req_ready   = '0;
    mem_addr    = '0;
    mem_data_in = '0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid == 2'b11) req_ready = prio_q ? 2'b10 : 2'b01;
        else                    req_ready = req_valid;
      end
      OWN0:    req_ready = {1'b0, req_valid[0]};
      OWN1:    req_ready = {req_valid[1], 1'b0};
      default: req_ready = '0;
    endcase
    // Ready is combinational, so it must be forced low while reset is held.
    if (!rst_n) req_ready = '0;

    accept  = req_ready & req_valid;
    win     = accept[1];
    cnt_inc = {1'b0, beat_cnt_q} + 9'd1;
    cap_hit = (cnt_inc == 9'(MAX_BURST));

    if (|accept) begin
      mem_addr    = win ? req_addr1  : req_addr0;
      mem_data_in = win ? req_wdata1 : req_wdata0;
      mem_we      = req_we[win];
      mem_re      = ~req_we[win];
      rsp_port_d  = req_we[win] ? 2'b00 : accept;
      if (req_last[win] || cap_hit) begin
        state_d     = IDLE;
        prio_d      = ~win;
        beat_cnt_d  = '0;
        burst_err_d = ~req_last[win] & cap_hit;
      end else begin
        state_d    = win ? OWN1 : OWN0;
        beat_cnt_d = cnt_inc[7:0];
      end
    end
  end

  assign rsp_valid = rsp_port_q;
  assign rsp_rdata = (|rsp_port_q) ? mem_data_out : '0;
  assign burst_err = burst_err_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Randomized bench for bram_port_arbiter: directed scenarios followed by random
// traffic, every cycle compared with a behavioural grant/ownership model.
module tb_bram_port_arbiter;
  localparam int DW    = 128;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int MB    = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req_valid, req_ready, req_we, req_last, rsp_valid;
  logic [AW-1:0] req_addr0, req_addr1, mem_addr;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, mem_data_in;
  logic [DW-1:0] mem_data_out = '0;
  logic          burst_err, mem_we, mem_re;

  always #5 clk = ~clk;

  bram_port_arbiter #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_last(req_last),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .burst_err(burst_err),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_re(mem_re),
    .mem_data_out(mem_data_out)
  );

  function automatic logic [DW-1:0] pattern(input int a);
    return {32'(4*a+1), 32'(4*a+2), 32'(4*a+3), 32'(4*a+4)};
  endfunction

  // BRAM: unwritten words read back as the preload pattern.
  logic [DW-1:0]    bram [DEPTH];
  logic [DEPTH-1:0] written = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr]    <= mem_data_in;
      written[mem_addr] <= 1'b1;
    end
    if (mem_re) mem_data_out <= written[mem_addr] ? bram[mem_addr] : pattern(int'(mem_addr));
  end

  // Reference model state
  logic [DW-1:0] mdl_mem [DEPTH];
  int            owner, prio_m, beats;
  logic [1:0]    pend, acc, last_ready;
  logic [DW-1:0] pend_data;
  logic          err_pend;
  int            checks = 0, errors = 0;
  int            rem [2];
  logic [1:0]    burst_we;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; prio_m = 0; beats = 0; pend = '0; err_pend = 1'b0; acc = '0;
  endtask

  task automatic set_req(input int p, input logic v, input logic we, input logic last,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = v; req_we[p] = we; req_last[p] = last;
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else        begin req_addr1 = a; req_wdata1 = d; end
  endtask

  // One cycle: compare at negedge, advance model, return at posedge+1.
  task automatic step();
    logic [1:0]    er;
    int            w, cnt;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    er = '0;
    if (rst_n) begin
      if (owner < 0) begin
        if (req_valid == 2'b11) er[prio_m] = 1'b1;
        else                    er = req_valid;
      end else er[owner] = req_valid[owner];
    end
    acc        = er & req_valid;
    last_ready = req_ready;
    check("ready", req_ready, er);
    check("rsp_valid", rsp_valid, pend);
    check("rsp_rdata", rsp_rdata, (pend != 0) ? pend_data : '0);
    check("burst_err", burst_err, err_pend);
    err_pend = 1'b0;
    pend     = '0;
    if (acc != 0) begin
      w = acc[1] ? 1 : 0;
      a = (w == 1) ? req_addr1 : req_addr0;
      d = (w == 1) ? req_wdata1 : req_wdata0;
      check("mem_ctl", {mem_we, mem_re, mem_addr}, {req_we[w], ~req_we[w], a});
      check("mem_wdata", mem_data_in, d);
      if (req_we[w]) mdl_mem[a] = d;
      else begin pend = acc; pend_data = mdl_mem[a]; end
      cnt = beats + 1;
      if (req_last[w] || cnt == MB) begin
        err_pend = !req_last[w] && cnt == MB;
        owner = -1; prio_m = 1 - w; beats = 0;
      end else begin
        owner = w; beats = cnt;
      end
    end else begin
      check("mem_idle", {mem_we, mem_re, mem_addr}, '0);
      check("mem_idle_d", mem_data_in, '0);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_rand();
    for (int p = 0; p < 2; p++) begin
      if (acc[p]) rem[p]--;
      if (acc[p] || !req_valid[p]) begin
        if ($urandom_range(0, 3) == 0) req_valid[p] = 1'b0;
        else begin
          if (rem[p] <= 0) begin
            rem[p] = ($urandom_range(0, 5) == 0) ? int'($urandom_range(17, 24)) : int'($urandom_range(1, 6));
            burst_we[p] = 1'($urandom_range(0, 1));
          end
          set_req(p, 1'b1, burst_we[p], rem[p] == 1, AW'($urandom_range(0, 15)),
                  {$urandom, $urandom, $urandom, $urandom});
        end
      end
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = pattern(i);
    req_valid = '0; req_we = '0; req_last = '0;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    rem[0] = 0; rem[1] = 0; burst_we = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", req_ready, '0);
    check("rst_rsp", {rsp_valid, burst_err, mem_we, mem_re, mem_addr}, '0);
    check("rst_rdata", rsp_rdata, '0);
    rst_n = 1'b1;

    // Single read of addr 0
    set_req(0, 1'b1, 1'b0, 1'b1, 8'd0, '0);
    step();
    check("t1_grant", last_ready, 2'b01);
    check("t1_rsp_v", rsp_valid, 2'b01);
    check("t1_rsp_d", rsp_rdata, 128'h00000001_00000002_00000003_00000004);
    req_valid = '0;
    step();

    // Both ports contend with single reads; prio now points at port 1
    set_req(0, 1'b1, 1'b0, 1'b1, 8'd1, '0);
    set_req(1, 1'b1, 1'b0, 1'b1, 8'd2, '0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t2_grant", last_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
      check("t2_rsp", rsp_rdata, (i % 2 == 0) ? 128'h00000009_0000000A_0000000B_0000000C
                                              : 128'h00000005_00000006_00000007_00000008);
    end

    // Port 1 write burst locks out waiting port 0
    set_req(0, 1'b1, 1'b0, 1'b1, 8'd5, '0);
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1'b1, 1'b1, i == 3, AW'(4 + i), {32{4'hA}});
      step();
      check("t3_block0", last_ready, 2'b10);
    end
    req_valid[1] = 1'b0;
    step();
    check("t3_grant0", last_ready, 2'b01);
    check("t3_rdata", rsp_rdata, {32{4'hA}});
    req_valid = '0;

    // Port 0 streams past MAX_BURST while port 1 waits
    n = 0;
    for (int c = 0; c < 22; c++) begin
      set_req(0, 1'b1, 1'b1, n == 20, AW'(16 + n), {4{32'(n)}});
      if (c == 1) set_req(1, 1'b1, 1'b0, 1'b1, 8'd9, '0);
      step();
      if (acc[0]) n++;
      if (acc[1]) req_valid[1] = 1'b0;
      check("t4_grant", last_ready, (c == 16) ? 2'b10 : 2'b01);
      if (c == 15 || c == 16) check("t4_err", burst_err, (c == 15) ? 1'b1 : 1'b0);
    end
    req_valid = '0;

    // Write then read-after-write of addr 3
    set_req(0, 1'b1, 1'b1, 1'b1, 8'd3, 128'h1234);
    step();
    set_req(0, 1'b1, 1'b0, 1'b1, 8'd3, '0);
    step();
    check("t5_raw", rsp_rdata, 128'h1234);
    req_valid = '0;

    // Reset mid-burst with a read in flight
    set_req(0, 1'b1, 1'b0, 1'b0, 8'd8, '0);
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rsp_drop", rsp_valid, 2'b00);
    check("t6_ready", req_ready, 2'b00);
    check("t6_mem", {mem_we, mem_re}, 2'b00);
    step();
    rst_n = 1'b1;
    set_req(1, 1'b1, 1'b0, 1'b1, 8'd2, '0);
    step();
    check("t6_grant", last_ready, 2'b01);
    req_last[0] = 1'b1;
    step();
    req_valid = '0;
    step();

    // Random traffic with occasional resets
    acc = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
      end else begin
        drive_rand();
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
